// File: rtl/perf_monitor.sv
// rtl/perf_monitor.sv - multi-channel run/event performance monitor
//
// Purpose: counts run cycles (channel 0) and per-cycle event strobes
// (channels 1..NUM_EVENTS) between a start request and a debounced
// final-PC detection, then freezes and raises a registered finished flag.
//
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high
//   en        in   start request, sampled in IDLE only
//   clear     in   synchronous soft clear of counters, flags and state
//   pc        in   observed CPU program counter
//   event_in  in   one-cycle event strobes, bit i counts into channel i+1
//   rd_sel    in   channel select, 0 = cycle counter
//   rd_data   out  registered value of the selected channel (1-cycle latency)
//   overflow  out  sticky per-channel overflow flags, bit 0 = cycle counter
//   running   out  high while counting
//   finished  out  high once the final PC has been held long enough
//
// Optional feature: PERF_SATURATE_EN defined makes counters saturate at
// all-ones; undefined, counters wrap to zero. Either way the overflow bit
// sets on the first increment attempted at all-ones.

module perf_monitor #(
   parameter int                  PC_WIDTH    = 16,
   parameter int                  CNT_WIDTH   = 32,
   parameter int                  NUM_EVENTS  = 4,
   parameter logic [PC_WIDTH-1:0] FINAL_PC    = 16'hFFFF,
   parameter int                  FINISH_HOLD = 2,
   localparam int                 SEL_W       = $clog2(NUM_EVENTS + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  clear,
   input  logic [PC_WIDTH-1:0]   pc,
   input  logic [NUM_EVENTS-1:0] event_in,
   input  logic [SEL_W-1:0]      rd_sel,
   output logic [CNT_WIDTH-1:0]  rd_data,
   output logic [NUM_EVENTS:0]   overflow,
   output logic                  running,
   output logic                  finished
);

   localparam int NCH = NUM_EVENTS + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q [NCH];
   logic [CNT_WIDTH-1:0] cnt_d [NCH];
   logic [7:0]           hold_q, hold_d;
   logic [NCH-1:0]       ovf_q, ovf_d;
   logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                 running_q, running_d;
   logic                 finished_q, finished_d;
   logic [NCH-1:0]       inc_vec;

   // Channel 0 counts every run cycle, so its increment request is constant.
   assign inc_vec = {event_in, 1'b1};

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      rd_data_d = '0;

      // Out-of-range selects fall through with zero.
      for (int i = 0; i < NCH; i++) begin
         if (rd_sel == SEL_W'(i)) begin
            rd_data_d = cnt_q[i];
         end
      end

      case (state_q)
         ST_IDLE: begin
            for (int i = 0; i < NCH; i++) begin
               cnt_d[i] = '0;
            end
            hold_d = '0;
            ovf_d  = '0;
            if (en) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            hold_d = (pc == FINAL_PC) ? hold_q + 8'd1 : 8'd0;
            for (int i = 0; i < NCH; i++) begin
               if (inc_vec[i]) begin
                  if (cnt_q[i] == '1) begin
                     ovf_d[i] = 1'b1;
`ifdef PERF_SATURATE_EN
                     cnt_d[i] = cnt_q[i];
`else
                     cnt_d[i] = '0;
`endif
                  end else begin
                     cnt_d[i] = cnt_q[i] + 1'b1;
                  end
               end
            end
            // The finishing cycle is still counted above.
            if (hold_d == 8'(FINISH_HOLD)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (clear) begin
         state_d = ST_IDLE;
         hold_d  = '0;
         ovf_d   = '0;
         for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = '0;
         end
         rd_data_d = '0;
      end

      // Status flags come straight from flops so the clock-gate enable
      // never sees decode glitches.
      running_d  = (state_d == ST_RUN);
      finished_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         hold_q     <= '0;
         ovf_q      <= '0;
         rd_data_q  <= '0;
         running_q  <= 1'b0;
         finished_q <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         ovf_q      <= ovf_d;
         rd_data_q  <= rd_data_d;
         running_q  <= running_d;
         finished_q <= finished_d;
         for (int i = 0; i < NCH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign rd_data  = rd_data_q;
   assign overflow = ovf_q;
   assign running  = running_q;
   assign finished = finished_q;

endmodule

// File: tb/tb_perf_monitor.sv
// tb/tb_perf_monitor.sv - directed self-checking bench for perf_monitor

module tb_perf_monitor;

   logic clk = 1'b0;
   logic reset;

   // Instance 1: 32-bit counters, hold of 2.
   logic        en1, clr1;
   logic [15:0] pc1;
   logic [3:0]  ev1;
   logic [2:0]  sel1;
   logic [31:0] rd1;
   logic [4:0]  ovf1;
   logic        run1, fin1;

   // Instance 2: 4-bit counters, hold of 3.
   logic        en2, clr2;
   logic [15:0] pc2;
   logic [3:0]  ev2;
   logic [2:0]  sel2;
   logic [3:0]  rd2;
   logic [4:0]  ovf2;
   logic        run2, fin2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   perf_monitor #(
      .PC_WIDTH(16), .CNT_WIDTH(32), .NUM_EVENTS(4),
      .FINAL_PC(16'h00FF), .FINISH_HOLD(2)
   ) u1 (
      .clk(clk), .reset(reset), .en(en1), .clear(clr1), .pc(pc1),
      .event_in(ev1), .rd_sel(sel1), .rd_data(rd1), .overflow(ovf1),
      .running(run1), .finished(fin1)
   );

   perf_monitor #(
      .PC_WIDTH(16), .CNT_WIDTH(4), .NUM_EVENTS(4),
      .FINAL_PC(16'h00FF), .FINISH_HOLD(3)
   ) u2 (
      .clk(clk), .reset(reset), .en(en2), .clear(clr2), .pc(pc2),
      .event_in(ev2), .rd_sel(sel2), .rd_data(rd2), .overflow(ovf2),
      .running(run2), .finished(fin2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic read1(input logic [2:0] s, input logic [31:0] exp, input string tag);
      sel1 = s;
      step();
      check(tag, rd1, exp);
   endtask

   initial begin
      reset = 1'b1;
      en1 = 0; clr1 = 0; pc1 = 0; ev1 = 0; sel1 = 0;
      en2 = 0; clr2 = 0; pc2 = 0; ev2 = 0; sel2 = 0;
      step();
      step();
      reset = 1'b0;

      check("rst_rd1",  rd1,  32'd0);
      check("rst_ovf1", ovf1, 32'd0);
      check("rst_run1", run1, 32'd0);
      check("rst_fin1", fin1, 32'd0);
      check("rst_run2", run2, 32'd0);
      check("rst_fin2", fin2, 32'd0);

      step();
      check("idle_stays", run1, 32'd0);

      // Basic run: pc = k sampled at edge N+1+k, 0xFF held for a second edge.
      pc1 = 16'h0000;
      en1 = 1'b1;
      step();
      en1 = 1'b0;
      check("basic_running", run1, 32'd1);
      for (int k = 0; k < 256; k++) begin
         pc1 = 16'(k);
         ev1 = (k >= 20 && k < 27) ? 4'b0010 : 4'b0000;
         step();
      end
      ev1 = 4'b0000;
      check("basic_not_yet_fin", fin1, 32'd0);
      check("basic_still_run",   run1, 32'd1);
      step();
      check("basic_fin",     fin1, 32'd1);
      check("basic_run_off", run1, 32'd0);

      // Freeze: DONE ignores events and pc.
      for (int i = 0; i < 20; i++) begin
         ev1 = (i % 2 == 1) ? 4'hF : 4'h0;
         pc1 = 16'(i);
         step();
      end
      ev1 = 4'h0;
      check("freeze_fin", fin1, 32'd1);

      read1(3'd0, 32'd257, "ch0");
      read1(3'd1, 32'd0,   "ch1");
      read1(3'd2, 32'd7,   "ch2");
      read1(3'd3, 32'd0,   "ch3");
      read1(3'd4, 32'd0,   "ch4");
      read1(3'd5, 32'd0,   "sel_out_of_range");
      check("ovf1_none", ovf1, 32'd0);

      // Read latency: switch 0 -> 1, data changes only at the next edge.
      read1(3'd0, 32'd257, "lat_sel0");
      sel1 = 3'd1;
      #2;
      check("lat_before_edge", rd1, 32'd257);
      step();
      check("lat_after_edge", rd1, 32'd0);

      // Clear priority over en while running.
      clr1 = 1'b1;
      step();
      clr1 = 1'b0;
      check("clr_done_fin", fin1, 32'd0);
      en1 = 1'b1;
      pc1 = 16'h0000;
      step();
      en1 = 1'b0;
      check("rerun_running", run1, 32'd1);
      repeat (5) step();
      clr1 = 1'b1;
      en1  = 1'b1;
      step();
      clr1 = 1'b0;
      en1  = 1'b0;
      check("clr_run_off", run1, 32'd0);
      check("clr_fin_off", fin1, 32'd0);
      check("clr_ovf",     ovf1, 32'd0);
      check("clr_rd",      rd1,  32'd0);
      sel1 = 3'd0;
      step();
      check("clr_ch0_zero",  rd1,  32'd0);
      check("clr_stay_idle", run1, 32'd0);
      en1 = 1'b1;
      step();
      en1 = 1'b0;
      check("restart_run", run1, 32'd1);
      repeat (3) step();
      step();
      check("restart_ch0", rd1, 32'd3);

      // Overflow with 4-bit counters: 14 plain + 3 final-PC cycles = 17 counts.
      en2 = 1'b1;
      pc2 = 16'h0000;
      step();
      en2 = 1'b0;
      repeat (14) step();
      pc2 = 16'h00FF;
      repeat (2) step();
      check("ovf_pre_fin", fin2, 32'd0);
      step();
      check("ovf_fin", fin2, 32'd1);
      sel2 = 3'd0;
      step();
`ifdef PERF_SATURATE_EN
      check("ovf_ch0", rd2, 32'd15);
`else
      check("ovf_ch0", rd2, 32'd1);
`endif
      check("ovf_flags", ovf2, 32'h01);

      // Glitch rejection with hold of 3.
      clr2 = 1'b1;
      step();
      clr2 = 1'b0;
      check("glitch_clr_ovf", ovf2, 32'd0);
      en2 = 1'b1;
      pc2 = 16'h0000;
      step();
      en2 = 1'b0;
      pc2 = 16'h00FF;
      repeat (2) step();
      check("glitch_run_a", run2, 32'd1);
      check("glitch_fin_a", fin2, 32'd0);
      pc2 = 16'h0010;
      step();
      check("glitch_run_b", run2, 32'd1);
      pc2 = 16'h00FF;
      repeat (2) step();
      check("glitch_run_c", run2, 32'd1);
      check("glitch_fin_c", fin2, 32'd0);
      step();
      check("glitch_fin", fin2, 32'd1);
      check("glitch_run_off", run2, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
